// File: rtl/down_count_timer.sv
// Loadable down-counter with a one-cycle done pulse on expiry.
// Define AUTO_RELOAD_EN for periodic mode (reload on expiry); otherwise one-shot.
module down_count_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             count,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             zero,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // load beats count; expiry is the COUNT-state decrement step from 1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= '0;
            reload_reg <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                out        <= load_val;
                reload_reg <= load_val;
                if (load_val != '0) begin
                    state <= COUNT;
                    busy  <= 1'b1;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else if (state == COUNT && count) begin
                if (out > WIDTH'(1)) begin
                    out <= out - WIDTH'(1);
                end else begin
                    done <= 1'b1;
`ifdef AUTO_RELOAD_EN
                    out  <= reload_reg;
`else
                    out   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
            end
        end
    end

    assign zero = (out == '0);

endmodule

// File: tb/tb_down_count_timer.sv
// Self-checking bench for down_count_timer (WIDTH = 8); checks one-shot or
// periodic behaviour depending on AUTO_RELOAD_EN.
module tb_down_count_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic [7:0] load_val;
    logic       count;
    logic [7:0] out;
    logic       busy;
    logic       zero;
    logic       done;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       ld;
        logic [7:0] val;
        logic       cnt;
        logic [7:0] e_out;
        logic       e_busy;
        logic       e_zero;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    down_count_timer #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .out      (out),
        .busy     (busy),
        .zero     (zero),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ld, input logic [7:0] val, input logic cnt);
        load     = ld;
        load_val = val;
        count    = cnt;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic ld, input logic [7:0] val, input logic cnt,
                                input logic [7:0] e_out, input logic e_busy,
                                input logic e_zero, input logic e_done);
        vec_t v;
        v.ld = ld; v.val = val; v.cnt = cnt;
        v.e_out = e_out; v.e_busy = e_busy; v.e_zero = e_zero; v.e_done = e_done;
        vecs.push_back(v);
    endfunction

    initial begin
`ifdef AUTO_RELOAD_EN
        add(1, 8'd2,   0, 8'd2, 1, 0, 0);
        add(0, 8'd0,   1, 8'd1, 1, 0, 0);
        add(0, 8'd0,   1, 8'd2, 1, 0, 1);
        add(0, 8'd0,   1, 8'd1, 1, 0, 0);
        add(0, 8'd0,   1, 8'd2, 1, 0, 1);
        add(0, 8'd0,   1, 8'd1, 1, 0, 0);
        add(0, 8'd0,   0, 8'd1, 1, 0, 0);
        add(0, 8'd0,   1, 8'd2, 1, 0, 1);
        add(1, 8'd0,   1, 8'd0, 0, 1, 0);
        add(0, 8'd0,   1, 8'd0, 0, 1, 0);
        add(1, 8'd1,   0, 8'd1, 1, 0, 0);
        add(0, 8'd0,   1, 8'd1, 1, 0, 1);
        add(0, 8'd0,   1, 8'd1, 1, 0, 1);
`else
        add(1, 8'd3,   0, 8'd3, 1, 0, 0);
        add(0, 8'd0,   1, 8'd2, 1, 0, 0);
        add(0, 8'd0,   1, 8'd1, 1, 0, 0);
        add(0, 8'd0,   1, 8'd0, 0, 1, 1);
        for (int i = 0; i < 5; i++) add(0, 8'd0, 1, 8'd0, 0, 1, 0);
        add(1, 8'd5,   0, 8'd5, 1, 0, 0);
        add(0, 8'd0,   1, 8'd4, 1, 0, 0);
        add(0, 8'd0,   1, 8'd3, 1, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 8'd0, 0, 8'd3, 1, 0, 0);
        add(0, 8'd0,   1, 8'd2, 1, 0, 0);
        add(0, 8'd0,   1, 8'd1, 1, 0, 0);
        add(0, 8'd0,   1, 8'd0, 0, 1, 1);
        add(0, 8'd0,   0, 8'd0, 0, 1, 0);
        add(1, 8'd9,   1, 8'd9, 1, 0, 0);
        for (int i = 8; i >= 2; i--) add(0, 8'd0, 1, 8'(i), 1, 0, 0);
        add(1, 8'd6,   1, 8'd6, 1, 0, 0);
        for (int i = 5; i >= 1; i--) add(0, 8'd0, 1, 8'(i), 1, 0, 0);
        add(1, 8'd4,   1, 8'd4, 1, 0, 0);
        add(0, 8'd0,   0, 8'd4, 1, 0, 0);
        add(1, 8'd0,   1, 8'd0, 0, 1, 0);
        add(0, 8'd0,   1, 8'd0, 0, 1, 0);
        add(1, 8'd255, 0, 8'd255, 1, 0, 0);
        add(0, 8'd0,   1, 8'd254, 1, 0, 0);
        add(1, 8'd1,   0, 8'd1, 1, 0, 0);
        add(0, 8'd0,   1, 8'd0, 0, 1, 1);
        add(0, 8'd0,   0, 8'd0, 0, 1, 0);
`endif

        reset = 1'b1;
        load = 1'b0;
        load_val = 8'd0;
        count = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset out",  32'(out),  32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset zero", 32'(zero), 32'd1);
        check_output("reset done", 32'(done), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].ld, vecs[i].val, vecs[i].cnt);
            check_output($sformatf("v%0d out",  i), 32'(out),  32'(vecs[i].e_out));
            check_output($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check_output($sformatf("v%0d zero", i), 32'(zero), 32'(vecs[i].e_zero));
            check_output($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].e_done));
        end

        // Asynchronous reset mid-count must clear outputs before the next edge
        apply_stimulus(1, 8'd6, 0);
        apply_stimulus(0, 8'd0, 1);
        apply_stimulus(0, 8'd0, 1);
        check_output("pre-reset out", 32'(out), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        check_output("async reset out",  32'(out),  32'd0);
        check_output("async reset busy", 32'(busy), 32'd0);
        check_output("async reset zero", 32'(zero), 32'd1);
        check_output("async reset done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(0, 8'd0, 1);
        check_output("post-reset idle out", 32'(out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
